// File: rtl/selnot_arbiter_if.sv
// Handshake bundle for selnot_arbiter: two requester channels, mode select and result channel.
// The master drives requests and q_ready; the slave (the arbiter) drives ready and result.
interface selnot_arbiter_if;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic [1:0] mode;
    logic       q_valid;
    logic [7:0] q_data;
    logic       q_src;
    logic       q_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data, mode, q_ready,
        input  a_ready, b_ready, q_valid, q_data, q_src
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, mode, q_ready,
        output a_ready, b_ready, q_valid, q_data, q_src
    );
endinterface

// File: rtl/selnot_arbiter.sv
// Two-requester arbiter feeding a single-entry output register holding ~operand of the winner.
// Modes: fixed-A, fixed-B (with starvation guard), round-robin, LFSR-random.
module selnot_arbiter #(
    parameter logic [7:0]  SEED       = 8'hA5,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    selnot_arbiter_if.slave bus
);
    localparam logic [7:0] LFSR_INIT  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic             q_valid_reg, q_valid_next;
    logic [7:0]       q_data_reg,  q_data_next;
    logic             q_src_reg,   q_src_next;
    logic             last_reg,    last_next;
    logic [7:0]       lfsr_reg,    lfsr_next;
    logic [1:0][7:0]  wait_reg,    wait_next;

    logic [1:0] valid_vec;
    logic [1:0] grant_vec;
    logic       out_open;
    logic       arb;
    logic       pick_b;
    logic       lfsr_fb;

    assign valid_vec = {bus.b_valid, bus.a_valid};
    assign lfsr_fb   = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    always_comb begin
        out_open = !q_valid_reg || bus.q_ready;
        // Gating with rst keeps both ready outputs low while reset is held.
        arb      = out_open && !rst && (|valid_vec);

        pick_b = 1'b0;
        case (bus.mode)
            2'b00:   pick_b = (wait_reg[1] == STARVE_LIM);
            2'b01:   pick_b = (wait_reg[0] != STARVE_LIM);
            2'b10:   pick_b = !last_reg;
            default: pick_b = lfsr_reg[0];
        endcase

        grant_vec = 2'b00;
        if (arb) begin
            if (&valid_vec) grant_vec = pick_b ? 2'b10 : 2'b01;
            else            grant_vec = valid_vec;
        end

        q_valid_next = q_valid_reg;
        q_data_next  = q_data_reg;
        q_src_next   = q_src_reg;
        last_next    = last_reg;
        lfsr_next    = lfsr_reg;
        if (|grant_vec) begin
            q_valid_next = 1'b1;
            q_data_next  = grant_vec[1] ? ~bus.b_data : ~bus.a_data;
            q_src_next   = grant_vec[1];
            last_next    = grant_vec[1];
            lfsr_next    = {lfsr_reg[6:0], lfsr_fb};
        end else if (out_open) begin
            q_valid_next = 1'b0;
        end
    end

    // Per-requester wait counters: cleared on grant or idle, saturating count of lost arbitrations.
    for (genvar gi = 0; gi < 2; gi++) begin : g_wait
        assign wait_next[gi] = (!valid_vec[gi] || grant_vec[gi]) ? 8'h00 :
                               (arb && wait_reg[gi] != 8'hFF)    ? wait_reg[gi] + 8'd1 :
                                                                   wait_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid_reg <= 1'b0;
            q_data_reg  <= 8'h00;
            q_src_reg   <= 1'b0;
            last_reg    <= 1'b1;
            lfsr_reg    <= LFSR_INIT;
            wait_reg    <= '0;
        end else begin
            q_valid_reg <= q_valid_next;
            q_data_reg  <= q_data_next;
            q_src_reg   <= q_src_next;
            last_reg    <= last_next;
            lfsr_reg    <= lfsr_next;
            wait_reg    <= wait_next;
        end
    end

    assign bus.a_ready = grant_vec[0];
    assign bus.b_ready = grant_vec[1];
    assign bus.q_valid = q_valid_reg;
    assign bus.q_data  = q_data_reg;
    assign bus.q_src   = q_src_reg;
endmodule

// File: tb/tb_selnot_arbiter.sv
// Directed bench for selnot_arbiter: fixed/starvation, round-robin, backpressure, LFSR and reset cases.
// A second instance with SEED=0 shares the stimulus and is checked only in random mode.
module tb_selnot_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    selnot_arbiter_if bus0 ();
    selnot_arbiter_if bus1 ();

    assign bus1.a_valid = bus0.a_valid;
    assign bus1.a_data  = bus0.a_data;
    assign bus1.b_valid = bus0.b_valid;
    assign bus1.b_data  = bus0.b_data;
    assign bus1.mode    = bus0.mode;
    assign bus1.q_ready = bus0.q_ready;

    selnot_arbiter #(.SEED(8'hA5), .STARVE_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    selnot_arbiter #(.SEED(8'h00), .STARVE_MAX(15)) dut_s0 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    initial begin
        logic [7:0] lf0;
        logic [7:0] lf1;

        bus0.a_valid = 1'b1;
        bus0.b_valid = 1'b1;
        bus0.a_data  = 8'h0F;
        bus0.b_data  = 8'h33;
        bus0.mode    = 2'b00;
        bus0.q_ready = 1'b1;
        tick();
        tick();
        check("reset q_valid", 8'(bus0.q_valid), 8'h00);
        check("reset q_data",  bus0.q_data,      8'h00);
        check("reset q_src",   8'(bus0.q_src),   8'h00);
        check("reset a_ready", 8'(bus0.a_ready), 8'h00);
        check("reset b_ready", 8'(bus0.b_ready), 8'h00);

        // Fixed-A with starvation grant of B on the 16th result.
        rst = 1'b0;
        #1;
        check("fixA first a_ready", 8'(bus0.a_ready), 8'h01);
        check("fixA first b_ready", 8'(bus0.b_ready), 8'h00);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("fixA c%0d q_src", i),  8'(bus0.q_src), 8'h00);
            check($sformatf("fixA c%0d q_data", i), bus0.q_data,    8'hF0);
        end
        #1;
        check("fixA starve b_ready", 8'(bus0.b_ready), 8'h01);
        tick();
        check("fixA c16 q_src",  8'(bus0.q_src), 8'h01);
        check("fixA c16 q_data", bus0.q_data,    8'hCC);
        tick();
        check("fixA c17 q_src",  8'(bus0.q_src), 8'h00);
        check("fixA c17 q_data", bus0.q_data,    8'hF0);

        // Round-robin, with an asynchronous reset mid-stream.
        bus0.mode = 2'b10;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr%0d a_ready", i), 8'(bus0.a_ready), 8'((i % 2) == 0));
            check($sformatf("rr%0d b_ready", i), 8'(bus0.b_ready), 8'((i % 2) == 1));
            tick();
            check($sformatf("rr%0d q_src", i), 8'(bus0.q_src), 8'(i % 2));
        end
        rst = 1'b1;
        #1;
        check("async rst q_valid", 8'(bus0.q_valid), 8'h00);
        check("async rst q_data",  bus0.q_data,      8'h00);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr post-rst%0d q_src", i), 8'(bus0.q_src), 8'(i % 2));
        end

        // Fixed-B mode with only A requesting.
        bus0.mode    = 2'b01;
        bus0.b_valid = 1'b0;
        bus0.a_data  = 8'hFF;
        do_reset();
        #1;
        check("solo A a_ready", 8'(bus0.a_ready), 8'h01);
        check("solo A b_ready", 8'(bus0.b_ready), 8'h00);
        tick();
        check("solo A q_valid", 8'(bus0.q_valid), 8'h01);
        check("solo A q_data",  bus0.q_data,      8'h00);
        check("solo A q_src",   8'(bus0.q_src),   8'h00);
        bus0.a_valid = 1'b0;
        tick();
        check("idle q_valid", 8'(bus0.q_valid), 8'h00);

        // Backpressure: result held, no grants, then immediate grant on release.
        bus0.mode    = 2'b00;
        bus0.a_valid = 1'b1;
        bus0.b_valid = 1'b1;
        bus0.a_data  = 8'h0F;
        bus0.q_ready = 1'b0;
        do_reset();
        tick();
        check("bp load q_data", bus0.q_data, 8'hF0);
        bus0.a_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d a_ready", i), 8'(bus0.a_ready), 8'h00);
            check($sformatf("bp%0d b_ready", i), 8'(bus0.b_ready), 8'h00);
            tick();
            check($sformatf("bp%0d q_valid", i), 8'(bus0.q_valid), 8'h01);
            check($sformatf("bp%0d q_data", i),  bus0.q_data,      8'hF0);
            check($sformatf("bp%0d q_src", i),   8'(bus0.q_src),   8'h00);
        end
        bus0.q_ready = 1'b1;
        #1;
        check("bp release a_ready", 8'(bus0.a_ready), 8'h01);
        tick();
        check("bp release q_data", bus0.q_data,    8'hAA);
        check("bp release q_src",  8'(bus0.q_src), 8'h00);

        // LFSR-random mode on both seeds.
        bus0.mode   = 2'b11;
        bus0.a_data = 8'h0F;
        do_reset();
        lf0 = 8'hA5;
        lf1 = 8'h01;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("lfsr A5 #%0d q_src", i), 8'(bus0.q_src), 8'(lf0[0]));
            check($sformatf("lfsr 00 #%0d q_src", i), 8'(bus1.q_src), 8'(lf1[0]));
            lf0 = lfsr_step(lf0);
            lf1 = lfsr_step(lf1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
